pipe_reg_chain: RTL and testbench

- Parametrised elastic pipeline register: DEPTH stages of W-bit data registers, each with a valid bit.
- Full valid/ready handshake on input and output, with per-stage bubble collapsing.
- Synchronous flush input.
- Replaces plain free-running datapath registers wherever the ALU datapath needs back-pressure-aware staging between producer and consumer.

---
 rtl/pipe_reg_chain.sv | 93 +++++++++
 tb/tb_pipe_reg_chain.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready pipeline register: DEPTH stages of W-bit data that collapse bubbles and support flush.
// Define PIPE_REG_OCC_EN to add the occupancy port, which gives the popcount of the stage valid bits.

module pipe_reg_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         en,
  input  logic         up_vld,
  input  logic [W-1:0] up_data,
  output logic         vld,
  output logic [W-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (flush) begin
      vld  <= 1'b0;
    end else if (en) begin
      vld <= up_vld;
      // a bubble moving in leaves the old data in place
      if (up_vld) data <= up_data;
    end
  end
endmodule

module pipe_reg_chain #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
  logic [DEPTH:0]            rdy;
  logic [DEPTH-1:0]          vld_pipe;
  logic [DEPTH-1:0][W-1:0]   data_pipe;
  logic [DEPTH-1:0]          up_vld;
  logic [DEPTH-1:0][W-1:0]   up_data;

  assign rdy[DEPTH] = out_ready;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_link
      // a stage can take a beat when it is empty or when its own beat moves on
      assign rdy[i] = !vld_pipe[i] || rdy[i+1];
      if (i == 0) begin : g_head
        assign up_vld[i]  = in_valid;
        assign up_data[i] = in_data;
      end else begin : g_body
        assign up_vld[i]  = vld_pipe[i-1];
        assign up_data[i] = data_pipe[i-1];
      end
    end
  endgenerate

  pipe_reg_stage #(.W(W)) u_stage [DEPTH-1:0] (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .en      (rdy[DEPTH-1:0]),
    .up_vld  (up_vld),
    .up_data (up_data),
    .vld     (vld_pipe),
    .data    (data_pipe)
  );

  assign in_ready  = rdy[0] && !flush && !rst;
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = data_pipe[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
  localparam int OW = $clog2(DEPTH+1);
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(vld_pipe[k]);
  end
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: runs DEPTH 2/3/4 instances on shared stimulus and checks them against a beat-position model.
module tb_pipe_reg_chain;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        iready [3];
  logic        ovalid [3];
  logic [31:0] odata  [3];
`ifdef PIPE_REG_OCC_EN
  logic [1:0]  occ0, occ1;
  logic [2:0]  occ2;
`endif

  always #5 clk = ~clk;

  pipe_reg_chain #(.W(32), .DEPTH(2)) u_d2 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(iready[0]), .in_data(in_data),
    .out_valid(ovalid[0]), .out_ready(out_ready), .out_data(odata[0])
`ifdef PIPE_REG_OCC_EN
    , .occupancy(occ0)
`endif
  );
  pipe_reg_chain #(.W(32), .DEPTH(3)) u_d3 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(iready[1]), .in_data(in_data),
    .out_valid(ovalid[1]), .out_ready(out_ready), .out_data(odata[1])
`ifdef PIPE_REG_OCC_EN
    , .occupancy(occ1)
`endif
  );
  pipe_reg_chain #(.W(32), .DEPTH(4)) u_d4 (.clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(iready[2]), .in_data(in_data),
    .out_valid(ovalid[2]), .out_ready(out_ready), .out_data(odata[2])
`ifdef PIPE_REG_OCC_EN
    , .occupancy(occ2)
`endif
  );

  // Model: each instance keeps its beats oldest-first together with their stage index.
  // A beat moves forward when the slot ahead is free or the beat ahead is also moving.
  int          dep [3] = '{2, 3, 4};
  int          cnt [3];
  int          pos [3][16];
  logic [31:0] dat [3][16];
  logic [31:0] last [3];
  bit          mv  [3][16];
  bit          mrdy [3];
  int          n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[D=%0d] got %h want %h", tag, dep[n], obs, exp);
    end
  endtask

  task automatic mcalc(input int n);
    for (int k = 0; k < cnt[n]; k++) begin
      if (k == 0) mv[n][k] = (pos[n][0] == dep[n]-1) ? out_ready : 1'b1;
      else        mv[n][k] = (pos[n][k]+1 < pos[n][k-1]) || mv[n][k-1];
    end
    mrdy[n] = (cnt[n] == 0) || (pos[n][cnt[n]-1] > 0) || mv[n][cnt[n]-1];
  endtask

  task automatic mupd(input int n);
    int j;
    mcalc(n);
    if (rst) begin
      cnt[n] = 0; last[n] = '0;
    end else if (flush) begin
      cnt[n] = 0;
    end else begin
      bit acc;
      acc = mrdy[n] && in_valid;
      j = 0;
      for (int k = 0; k < cnt[n]; k++) begin
        if (mv[n][k] && pos[n][k] == dep[n]-1) continue;
        pos[n][j] = mv[n][k] ? pos[n][k]+1 : pos[n][k];
        dat[n][j] = dat[n][k];
        if (mv[n][k] && pos[n][j] == dep[n]-1) last[n] = dat[n][j];
        j++;
      end
      if (acc) begin
        pos[n][j] = 0; dat[n][j] = in_data;
        if (dep[n] == 1) last[n] = in_data;
        j++;
      end
      cnt[n] = j;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      mcalc(n);
      chk("in_ready",  n, 32'(iready[n]), 32'(mrdy[n] && !flush && !rst));
      chk("out_valid", n, 32'(ovalid[n]), 32'(cnt[n] > 0 && pos[n][0] == dep[n]-1));
      chk("out_data",  n, odata[n], last[n]);
    end
`ifdef PIPE_REG_OCC_EN
    chk("occupancy", 0, 32'(occ0), 32'(cnt[0]));
    chk("occupancy", 1, 32'(occ1), 32'(cnt[1]));
    chk("occupancy", 2, 32'(occ2), 32'(cnt[2]));
`endif
    @(posedge clk);
    for (int n = 0; n < 3; n++) mupd(n);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy);
    in_valid = v; in_data = d; out_ready = ordy;
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin cnt[n] = 0; last[n] = '0; end
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    tick();
    // streaming
    for (int k = 1; k <= 3; k++) begin drive(1'b1, 32'(k), 1'b1); tick(); end
    drive(1'b0, 32'h0, 1'b1);
    repeat (5) tick();
    // back-pressure fill then drain
    for (int k = 0; k < 6; k++) begin drive(1'b1, 32'hA0 + 32'(k), 1'b0); tick(); end
    drive(1'b1, 32'hA5, 1'b1);
    repeat (3) tick();
    drive(1'b0, 32'h0, 1'b1);
    repeat (6) tick();
    // full with simultaneous in/out
    drive(1'b1, 32'h11, 1'b0); tick();
    drive(1'b1, 32'h22, 1'b0); tick();
    drive(1'b1, 32'h55, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1);
    repeat (5) tick();
    // flush mid-stream
    for (int k = 0; k < 3; k++) begin drive(1'b1, 32'h70 + 32'(k), 1'b0); tick(); end
    flush = 1'b1; drive(1'b1, 32'h77, 1'b0); tick();
    flush = 1'b0; drive(1'b0, 32'h0, 1'b0); repeat (2) tick();
    drive(1'b0, 32'h0, 1'b1); repeat (4) tick();
    // bubble collapse with a stalled consumer
    drive(1'b1, 32'hB1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0); repeat (4) tick();
    drive(1'b0, 32'h0, 1'b1); repeat (3) tick();
    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
      flush = ($urandom % 40) == 0;
      rst   = ($urandom % 97) == 0;
      tick();
    end
    rst = 1'b0; flush = 1'b0; drive(1'b0, 32'h0, 1'b1);
    repeat (6) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
